// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// RAW-hazard scoreboard for the decode stage. Each architectural register has
// a small countdown holding the number of cycles until its in-flight result
// reaches a forwardable point. Decode sees a combinational stall whenever a
// source operand is not yet forwardable. An early consumer (branch, JR/JALR)
// needs the value in ID, so any non-zero count stalls it. A normal consumer
// picks the value up from the forwarding network one stage later, so it only
// stalls while the count is above one. A saturating counter records the
// number of stalled, unheld cycles for performance monitoring.
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           asynchronous active-high reset
//   issue_valid_i   a valid instruction sits in ID
//   issue_wr_en_i   the ID instruction writes a register
//   issue_rd_i      destination register index
//   issue_lat_i     producer latency (0 ALU, 1 load, >1 slow/multicycle)
//   src1_valid_i    source 1 is actually read
//   src1_i          source 1 register index
//   src2_valid_i    source 2 is actually read
//   src2_i          source 2 register index
//   src_early_i     consumer needs its operands in ID
//   pipe_hold_i     backend frozen; countdowns hold, no issue accepted
//   flush_id_i      ID instruction squashed this cycle
//   stall_o         hold IF/ID and inject a bubble (combinational)
//   pending_o       bit r set while register r has a non-zero countdown
//   stall_cycles_o  saturating count of stalled, unheld cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int MAX_LAT  = 3,
    parameter int LAT_W    = 2,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    input  logic                issue_wr_en_i,
    input  logic [REG_W-1:0]    issue_rd_i,
    input  logic [LAT_W-1:0]    issue_lat_i,
    input  logic                src1_valid_i,
    input  logic [REG_W-1:0]    src1_i,
    input  logic                src2_valid_i,
    input  logic [REG_W-1:0]    src2_i,
    input  logic                src_early_i,
    input  logic                pipe_hold_i,
    input  logic                flush_id_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [PERF_W-1:0]   stall_cycles_o
);

    logic [CNT_W-1:0]  cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d [NUM_REGS];
    logic [PERF_W-1:0] perf_q;
    logic [PERF_W-1:0] perf_d;

    logic [CNT_W-1:0]  src1_cnt_s;
    logic [CNT_W-1:0]  src2_cnt_s;
    logic [CNT_W-1:0]  lat_clip_s;
    logic [CNT_W-1:0]  issue_val_s;
    logic              hz1_s;
    logic              hz2_s;
    logic              stall_s;
    logic              accept_s;

    // Early consumers need the value now; others can take it off the bypass
    // one cycle later, so a count of exactly one is still safe for them.
    function automatic logic src_hazard(input logic             vld,
                                        input logic             early,
                                        input logic [CNT_W-1:0] c);
        logic hz;
        if (early) begin
            hz = (c != {CNT_W{1'b0}});
        end else begin
            hz = (c > CNT_W'(1));
        end
        return vld & hz;
    endfunction

    // Look up source countdowns; indices beyond the register file never hazard.
    always_comb begin
        src1_cnt_s = {CNT_W{1'b0}};
        src2_cnt_s = {CNT_W{1'b0}};
        if (32'(src1_i) < 32'(NUM_REGS)) begin
            src1_cnt_s = cnt_q[src1_i];
        end else begin
            src1_cnt_s = {CNT_W{1'b0}};
        end
        if (32'(src2_i) < 32'(NUM_REGS)) begin
            src2_cnt_s = cnt_q[src2_i];
        end else begin
            src2_cnt_s = {CNT_W{1'b0}};
        end
    end

    // Hazard detection, stall and issue acceptance (all on the old counts).
    always_comb begin
        hz1_s    = src_hazard(src1_valid_i, src_early_i, src1_cnt_s);
        hz2_s    = src_hazard(src2_valid_i, src_early_i, src2_cnt_s);
        stall_s  = issue_valid_i & ~flush_id_i & (hz1_s | hz2_s);
        accept_s = issue_valid_i & ~stall_s & ~pipe_hold_i & ~flush_id_i;
    end

    // Countdown loaded on issue: clipped latency plus one cycle to forward.
    always_comb begin
        lat_clip_s = {CNT_W{1'b0}};
        if (32'(issue_lat_i) > 32'(MAX_LAT)) begin
            lat_clip_s = CNT_W'(MAX_LAT);
        end else begin
            lat_clip_s = CNT_W'(issue_lat_i);
        end
        issue_val_s = lat_clip_s + CNT_W'(1);
    end

    // Next-state countdowns: hold wins, then a new issue, then decrement.
    // An out-of-range destination matches no entry, so its write is dropped.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (pipe_hold_i) begin
                cnt_d[r] = cnt_q[r];
            end else if (accept_s && issue_wr_en_i && (issue_rd_i == REG_W'(r))) begin
                cnt_d[r] = issue_val_s;
            end else if (cnt_q[r] != {CNT_W{1'b0}}) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Next-state stall-cycle counter, saturating at all ones.
    always_comb begin
        perf_d = perf_q;
        if (stall_s && !pipe_hold_i && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + PERF_W'(1);
        end else begin
            perf_d = perf_q;
        end
    end

    // Countdown and performance-counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= {CNT_W{1'b0}};
            end
            perf_q <= {PERF_W{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            perf_q <= perf_d;
        end
    end

    // Pending flags straight from the countdown registers.
    always_comb begin
        pending_o = {NUM_REGS{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_o[r] = (cnt_q[r] != {CNT_W{1'b0}});
        end
    end

    assign stall_o        = stall_s;
    assign stall_cycles_o = perf_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_scoreboard. The reference model keeps, per register,
// the absolute "unheld-cycle time" at which its result becomes forwardable;
// the remaining distance is that time minus the current unheld-cycle count.
// The performance counter is built with PERF_W = 8 so that saturation can be
// reached in a few hundred cycles.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;
    localparam int MAX_LAT  = 3;
    localparam int LAT_W    = 2;
    localparam int CNT_W    = 3;
    localparam int PERF_W   = 8;
    localparam int PMAX     = (1 << PERF_W) - 1;

    logic                clk;
    logic                rst;
    logic                issue_valid;
    logic                issue_wr_en;
    logic [REG_W-1:0]    issue_rd;
    logic [LAT_W-1:0]    issue_lat;
    logic                src1_valid;
    logic [REG_W-1:0]    src1;
    logic                src2_valid;
    logic [REG_W-1:0]    src2;
    logic                src_early;
    logic                pipe_hold;
    logic                flush_id;
    logic                stall;
    logic [NUM_REGS-1:0] pending;
    logic [PERF_W-1:0]   stall_cycles;

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .MAX_LAT(MAX_LAT),
        .LAT_W(LAT_W), .CNT_W(CNT_W), .PERF_W(PERF_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_wr_en_i(issue_wr_en),
        .issue_rd_i(issue_rd), .issue_lat_i(issue_lat),
        .src1_valid_i(src1_valid), .src1_i(src1),
        .src2_valid_i(src2_valid), .src2_i(src2),
        .src_early_i(src_early), .pipe_hold_i(pipe_hold), .flush_id_i(flush_id),
        .stall_o(stall), .pending_o(pending), .stall_cycles_o(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int tick;
    int ready [NUM_REGS];
    int perf_m;

    // last observed DUT outputs from drive()
    logic                last_stall;
    logic [NUM_REGS-1:0] last_pend;
    logic [PERF_W-1:0]   last_perf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rem(input int r);
        return (ready[r] > tick) ? (ready[r] - tick) : 0;
    endfunction

    function automatic bit hz(input bit v, input int idx, input bit early);
        if (!v || idx >= NUM_REGS) return 1'b0;
        if (early) return rem(idx) > 0;
        return rem(idx) > 1;
    endfunction

    task automatic model_reset();
        tick   = 0;
        perf_m = 0;
        for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance.
    task automatic drive(input bit v, input bit wr, input int rd, input int lat,
                         input bit s1v, input int s1, input bit s2v, input int s2,
                         input bit early, input bit hold, input bit flush);
        bit                  exp_s;
        logic [NUM_REGS-1:0] exp_p;
        @(negedge clk);
        issue_valid = v;
        issue_wr_en = wr;
        issue_rd    = REG_W'(rd);
        issue_lat   = LAT_W'(lat);
        src1_valid  = s1v;
        src1        = REG_W'(s1);
        src2_valid  = s2v;
        src2        = REG_W'(s2);
        src_early   = early;
        pipe_hold   = hold;
        flush_id    = flush;
        #1;
        exp_s = v && !flush && (hz(s1v, s1, early) || hz(s2v, s2, early));
        for (int r = 0; r < NUM_REGS; r++) exp_p[r] = (rem(r) != 0);
        chk("stall", 32'(stall), 32'(exp_s));
        chk("pending", 32'(pending), 32'(exp_p));
        chk("stall_cycles", 32'(stall_cycles), 32'(perf_m));
        last_stall = stall;
        last_pend  = pending;
        last_perf  = stall_cycles;
        @(posedge clk);
        if (!hold) begin
            if (exp_s && perf_m < PMAX) perf_m++;
            if (v && wr && !exp_s && !flush && rd < NUM_REGS)
                ready[rd] = tick + 2 + ((lat > MAX_LAT) ? MAX_LAT : lat);
            tick++;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Present the same consumer until it issues; returns the stall count.
    task automatic issue_wait(input bit wr, input int rd, input int lat,
                              input bit s1v, input int s1, input bit s2v, input int s2,
                              input bit early, output int n);
        n = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1, wr, rd, lat, s1v, s1, s2v, s2, early, 0, 0);
            if (last_stall !== 1'b1) break;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        int s;
        int p0;

        rst = 1'b1;
        issue_valid = 1'b0; issue_wr_en = 1'b0; issue_rd = '0; issue_lat = '0;
        src1_valid = 1'b0; src1 = '0; src2_valid = 1'b0; src2 = '0;
        src_early = 1'b0; pipe_hold = 1'b0; flush_id = 1'b0;
        model_reset();
        #1;
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_perf", 32'(stall_cycles), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ALU -> ALU: no bubble, pending for one cycle
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_wait(0, 0, 0, 1, 3, 0, 0, 0, n);
        chk("alu_alu_bubbles", 32'(n), 32'(0));
        chk("alu_pend_hi", 32'(last_pend[3]), 32'(1));
        idle();
        chk("alu_pend_lo", 32'(last_pend[3]), 32'(0));

        // load -> ALU: one bubble, counter reads 1
        drive(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        issue_wait(0, 0, 0, 0, 0, 1, 2, 0, n);
        chk("load_alu_bubbles", 32'(n), 32'(1));
        idle();
        chk("perf_one", 32'(last_perf), 32'(1));

        // ALU -> branch: one bubble
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_wait(0, 0, 0, 1, 3, 0, 0, 1, n);
        chk("alu_br_bubbles", 32'(n), 32'(1));

        // load -> branch: two bubbles
        drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        issue_wait(0, 0, 0, 1, 5, 0, 0, 1, n);
        chk("load_br_bubbles", 32'(n), 32'(2));

        // load, independent, branch: one bubble
        drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
        issue_wait(0, 0, 0, 1, 5, 0, 0, 1, n);
        chk("load_ind_br_bubbles", 32'(n), 32'(1));

        // latency 3 producer with a 2-cycle hold in the middle of the wait
        idle();
        p0 = int'(last_perf);
        drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        s = 0;
        repeat (2) begin
            drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
            if (last_stall === 1'b1) s++;
        end
        repeat (2) begin
            drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
            if (last_stall === 1'b1) s++;
        end
        issue_wait(0, 0, 0, 1, 1, 0, 0, 0, n);
        chk("hold_stall_total", 32'(s + n), 32'(5));
        idle();
        chk("hold_perf_delta", 32'(last_perf), 32'(p0 + 3));

        // back-to-back writes to r4: second (ALU) overrides the load
        drive(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_wait(0, 0, 0, 0, 0, 1, 4, 0, n);
        chk("override_bubbles", 32'(n), 32'(0));

        // flush on a hazard: no stall, no write, counters keep decrementing
        drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 3, 1, 6, 0, 0, 0, 0, 1);
        chk("flush_stall", 32'(last_stall), 32'(0));
        idle();
        chk("flush_nowrite", 32'(last_pend[0]), 32'(0));
        chk("flush_dec_a", 32'(last_pend[6]), 32'(1));
        idle();
        chk("flush_dec_b", 32'(last_pend[6]), 32'(0));

        // asynchronous reset while stalled on r6 with count 3
        drive(1, 1, 6, 3, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'(1));
        chk("pre_rst_pend6", 32'(pending[6]), 32'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'(0));
        chk("mid_rst_pending", 32'(pending), 32'(0));
        chk("mid_rst_perf", 32'(stall_cycles), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        chk("post_rst_stall", 32'(last_stall), 32'(0));

        // randomized traffic against the model
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
        end

        // drive the stall counter past saturation (4 stalls per iteration)
        for (int k = 0; k < 70; k++) begin
            drive(1, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0);
            issue_wait(0, 0, 0, 1, 5, 0, 0, 1, n);
        end
        idle();
        chk("perf_saturated", 32'(last_perf), 32'(PMAX));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW-hazard scoreboard for the decode stage of the pipelined core, the next generation of the fixed two-stage load/branch stall logic. A per-register countdown tracks how many cycles remain until each in-flight result can be forwarded. It generalises the hazard check to any register-file size and any producer latency (ALU, load, multi-cycle memory). Decode consumes a combinational `stall`; the block also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `NUM_REGS`, 8, number of architectural registers
- `REG_W`, 3, register index width; `NUM_REGS` must be ≤ 2^`REG_W`
- `MAX_LAT`, 3, largest producer latency accepted on `issue_lat`
- `LAT_W`, 2, width of `issue_lat`
- `CNT_W`, 3, per-register counter width; must satisfy 2^`CNT_W` > `MAX_LAT`+1
- `PERF_W`, 16, stall-cycle counter width

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `issue_valid` in 1: a valid instruction is in ID
- `issue_wr_en` in 1: the ID instruction writes a register
- `issue_rd` in `REG_W`: destination register
- `issue_lat` in `LAT_W`: producer latency (0 = ALU, 1 = load, >1 = slow memory/multicycle)
- `src1_valid`, `src2_valid` in 1: source operand is actually read
- `src1`, `src2` in `REG_W`: source register indices
- `src_early` in 1: consumer needs operands in ID (branch, JR/JALR)
- `pipe_hold` in 1: backend frozen (memory busy); counters freeze
- `flush_id` in 1: the ID instruction is squashed this cycle
- `stall` out 1: hold IF/ID and inject a bubble
- `pending` out `NUM_REGS`: bit r = `cnt[r]` ≠ 0
- `stall_cycles` out `PERF_W`: saturating count of stalled cycles

## Operation
- State: `cnt[r]`, `CNT_W` bits, for r in 0..`NUM_REGS`-1. The value is the distance in cycles until the result reaches a forwardable point.
- Hazard per source s: `hz_s` = `src_s_valid` & (`src_early` ? `cnt[src_s]` > 0 : `cnt[src_s]` > 1).
- `stall` = `issue_valid` & ~`flush_id` & (`hz_1` | `hz_2`). It is purely combinational from the current `cnt` values and inputs.
- Issue accepted when `issue_valid` & ~`stall` & ~`pipe_hold` & ~`flush_id`.
- On an accepted issue with `issue_wr_en`: `cnt[issue_rd]` ← min(`issue_lat`, `MAX_LAT`) + 1.
- Every other register with ~`pipe_hold`: `cnt` ← `cnt` − 1, saturating at 0.
- `pipe_hold`=1: all `cnt` hold, and no issue is accepted.
- Same-cycle issue to a register that is also decrementing: the issue value wins.
- Self-dependency (rd equals a source): the hazard is evaluated on the old `cnt`; the write happens after.
- Index ≥ `NUM_REGS` on `src_s`: treated as no hazard. On `issue_rd`: the write is ignored.
- `stall_cycles` increments when `stall` & ~`pipe_hold`, saturating at all-ones.
- Resulting behaviour:
  - ALU→ALU: 0 bubbles.
  - ALU→branch: 1 bubble.
  - load→ALU: 1 bubble.
  - load→branch: 2 bubbles.
  - load, independent instruction, branch: 1 bubble.

## Timing
- Reset (asynchronous, immediate): all `cnt` = 0, `pending` = 0, `stall` = 0, `stall_cycles` = 0.
- Reset asserted mid-stall clears all hazards. The first cycle after deassertion issues without stalling.
- `stall` has zero latency: same cycle as the inputs, with no registered path from input to `stall`.
- `cnt` and `pending` update one cycle after an accepted issue. `pending[rd]` rises on the edge following issue.
- A latency-L producer clears `pending` after exactly L+1 unheld cycles. Held cycles extend this one-for-one.
- `flush_id` in the same cycle as a hazard: `stall`=0, there is no write, and counters still decrement.

## Test plan
- Reset, then ALU write r3 (lat 0), next cycle ALU reads r3 → `stall`=0 both cycles; `pending[3]`=1 for one cycle.
- Load r2 (lat 1), next cycle ALU reads r2 → `stall`=1 for exactly 1 cycle, then issues; `stall_cycles`=1.
- Load r5, next cycle branch (`src_early`) on r5 → 2 stall cycles. Repeat with one independent instruction in between → 1 stall cycle.
- Producer lat 3 on r1, consumer on r1 with `pipe_hold` high for 2 cycles mid-wait → `stall` lasts 3+2 cycles; `cnt[1]` is frozen while held.
- Back-to-back writes to r4 (lat 1, then lat 0), then a reader → the second write overrides; reader sees `cnt`=1 and does not stall. Simultaneous `flush_id` on a hazard → `stall`=0 and no write.
- Assert `rst` while `cnt[6]`=3 and stalled → `stall` and `pending` drop to 0 immediately. Drive 2^`PERF_W`+5 stall cycles → `stall_cycles` saturates at all-ones.
